// File: rtl/ex_muldiv_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ex_muldiv_sched_pkg
// Description : Shared encodings for the RV64M multi-cycle scheduler:
//               opcode/funct fields, MDU state encoding and signedness helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_muldiv_sched_pkg;

    // R-type opcode and the funct7 value that marks an M-extension op
    localparam logic [6:0] c_OPCODE_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_FUNCT7_MULDIV = 7'b0000001;

    // funct3 selectors for the eight M ops
    localparam logic [2:0] c_FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] c_FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] c_FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] c_FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] c_FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] c_FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] c_FUNCT3_REM    = 3'b110;
    localparam logic [2:0] c_FUNCT3_REMU   = 3'b111;

    // MDU state encoding
    localparam logic [1:0] c_MDU_IDLE = 2'd0;
    localparam logic [1:0] c_MDU_BUSY = 2'd1;
    localparam logic [1:0] c_MDU_DONE = 2'd2;

    // rs1 is interpreted as two's complement for these ops
    function automatic logic operand_a_signed(input logic [2:0] funct3);
        return funct3 inside {c_FUNCT3_MUL, c_FUNCT3_MULH, c_FUNCT3_MULHSU,
                              c_FUNCT3_DIV, c_FUNCT3_REM};
    endfunction

    // rs2 is interpreted as two's complement for these ops
    function automatic logic operand_b_signed(input logic [2:0] funct3);
        return funct3 inside {c_FUNCT3_MUL, c_FUNCT3_MULH,
                              c_FUNCT3_DIV, c_FUNCT3_REM};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_sched_iter.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_sched_iter
// Description : Unsigned iterative datapath. Multiply is shift-add over a
//               2*XLEN accumulator {hi, lo}; divide is restoring division with
//               the partial remainder in hi and the quotient shifting into lo.
//               One iteration per cycle while i_step is high. The next-state
//               accumulator is exported so the caller can capture the result on
//               the same edge as the final iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_sched_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_md,
    input  logic [XLEN-1:0] i_init,
    output logic [XLEN-1:0] o_hi_nxt,
    output logic [XLEN-1:0] o_lo_nxt
);

    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_md;
    logic            r_div;

    logic [XLEN:0]   w_add;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shl;
    logic [XLEN:0]   w_trial;

    // Multiply: add multiplicand when the current multiplier bit is set
    assign w_add   = {1'b0, r_hi} + {1'b0, r_md};
    assign w_sum   = r_lo[0] ? w_add : {1'b0, r_hi};
    // Divide: shift next dividend bit into the remainder, trial-subtract divisor.
    // Since hi < divisor is invariant, a set MSB of w_trial means a borrow.
    assign w_shl   = {r_hi, r_lo[XLEN-1]};
    assign w_trial = w_shl - {1'b0, r_md};

    // Next accumulator value for one iteration of the selected operation
    always_comb begin
        o_hi_nxt = r_hi;
        o_lo_nxt = r_lo;
        if (r_div) begin
            if (!w_trial[XLEN]) begin
                o_hi_nxt = w_trial[XLEN-1:0];
                o_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                o_hi_nxt = w_shl[XLEN-1:0];
                o_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            o_hi_nxt = w_sum[XLEN:1];
            o_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    // Accumulator/operand registers: loaded at accept, advanced while stepping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_md  <= '0;
            r_div <= 1'b0;
        end else if (i_load) begin
            r_hi  <= '0;
            r_lo  <= i_init;
            r_md  <= i_md;
            r_div <= i_is_div;
        end else if (i_step) begin
            r_hi  <= o_hi_nxt;
            r_lo  <= o_lo_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_sched.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_sched
// Description : Multi-cycle scheduler for RV64M ops in the EX stage. Accepts an
//               M op, stalls the front of the pipeline while the iterative
//               datapath runs, and presents rd/wreg/wdata with a one-cycle
//               done_o pulse. Divide-by-zero and signed overflow finish in one
//               cycle without iterating.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_sched
    import ex_muldiv_sched_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [4:0]      rd_addr_o,
    output logic            wreg_o,
    output logic [XLEN-1:0] wdata_o
);

    localparam logic [XLEN-1:0]  c_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(XLEN - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_funct3;
    logic              r_sa;
    logic              r_sb;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_wdata;

    logic              w_is_m;
    logic              w_start;
    logic              w_sa;
    logic              w_sb;
    logic              w_is_div;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic              w_last;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN-1:0]   w_hi_nxt;
    logic [XLEN-1:0]   w_lo_nxt;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_iter_res;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;

    // ------------------------------------------------------------------
    // Decode and operand conditioning
    // ------------------------------------------------------------------
    assign w_is_m   = valid_i && (opcode_i == c_OPCODE_RTYPE) && (funct7_i == c_FUNCT7_MULDIV);
    assign w_start  = w_is_m && (r_state == c_MDU_IDLE) && !flush_i;
    assign w_is_div = funct3_i[2];

    assign w_sa     = operand_a_signed(funct3_i) && rs1_data_i[XLEN-1];
    assign w_sb     = operand_b_signed(funct3_i) && rs2_data_i[XLEN-1];
    assign w_mag_a  = w_sa ? -rs1_data_i : rs1_data_i;
    assign w_mag_b  = w_sb ? -rs2_data_i : rs2_data_i;

    assign w_div_zero = w_is_div && (rs2_data_i == '0);
    assign w_ovf      = ((funct3_i == c_FUNCT3_DIV) || (funct3_i == c_FUNCT3_REM)) &&
                        (rs1_data_i == c_MIN_NEG) && (rs2_data_i == '1);
    assign w_special  = w_div_zero || w_ovf;

    // Results for the cases that bypass iteration; funct3[1] picks REM over DIV
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = funct3_i[1] ? rs1_data_i : '1;
        end else if (w_ovf) begin
            w_special_res = funct3_i[1] ? '0 : rs1_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath (multiplicand/divisor in md, multiplier/dividend in init)
    // ------------------------------------------------------------------
    ex_muldiv_sched_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_start && !w_special),
        .i_step   ((r_state == c_MDU_BUSY) && !flush_i),
        .i_is_div (w_is_div),
        .i_md     (w_is_div ? w_mag_b : w_mag_a),
        .i_init   (w_is_div ? w_mag_a : w_mag_b),
        .o_hi_nxt (w_hi_nxt),
        .o_lo_nxt (w_lo_nxt)
    );

    // ------------------------------------------------------------------
    // Sign fix and result selection from the post-final-iteration accumulator
    // ------------------------------------------------------------------
    assign w_last     = (r_state == c_MDU_BUSY) && (r_cnt == c_LAST_CNT);
    assign w_prod     = {w_hi_nxt, w_lo_nxt};
    assign w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;
    assign w_quot     = (r_sa ^ r_sb) ? -w_lo_nxt : w_lo_nxt;
    assign w_rem      = r_sa ? -w_hi_nxt : w_hi_nxt;

    // Pick the result half or quotient/remainder for the latched funct3
    always_comb begin
        case (r_funct3)
            c_FUNCT3_MUL:    w_iter_res = w_prod_fix[XLEN-1:0];
            c_FUNCT3_MULH,
            c_FUNCT3_MULHSU,
            c_FUNCT3_MULHU:  w_iter_res = w_prod_fix[2*XLEN-1:XLEN];
            c_FUNCT3_DIV,
            c_FUNCT3_DIVU:   w_iter_res = w_quot;
            default:         w_iter_res = w_rem;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM, iteration counter and output registers
    // ------------------------------------------------------------------
    // Sequence IDLE -> BUSY -> DONE -> IDLE; flush aborts without a result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_MDU_IDLE;
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_rd     <= '0;
            r_wdata  <= '0;
        end else if (flush_i) begin
            r_state  <= c_MDU_IDLE;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                c_MDU_IDLE: begin
                    if (w_start) begin
                        r_cnt    <= '0;
                        r_funct3 <= funct3_i;
                        r_sa     <= w_sa;
                        r_sb     <= w_sb;
                        r_rd     <= rd_addr_i;
                        if (w_special) begin
                            r_state <= c_MDU_DONE;
                            r_wdata <= w_special_res;
                        end else begin
                            r_state <= c_MDU_BUSY;
                        end
                    end
                end
                c_MDU_BUSY: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= c_MDU_DONE;
                        r_wdata <= w_iter_res;
                    end
                end
                c_MDU_DONE: begin
                    r_state <= c_MDU_IDLE;
                end
                default: begin
                    r_state <= c_MDU_IDLE;
                end
            endcase
        end
    end

    // The accepting cycle already stalls; DONE releases the pipeline once
    assign stall_o   = w_start || (r_state == c_MDU_BUSY);
    assign busy_o    = (r_state != c_MDU_IDLE);
    assign done_o    = (r_state == c_MDU_DONE) && !flush_i;
    assign wreg_o    = done_o && (r_rd != 5'd0);
    assign rd_addr_o = r_rd;
    assign wdata_o   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_sched
// Description : Self-checking bench for ex_muldiv_sched. Directed and random
//               M ops checked against an arithmetic reference model, including
//               cycle-accurate stall/busy/done timing, flush and reset aborts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_sched;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst;
    logic            valid_i;
    logic [6:0]      opcode_i;
    logic [2:0]      funct3_i;
    logic [6:0]      funct7_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [4:0]      rd_addr_o;
    logic            wreg_o;
    logic [XLEN-1:0] wdata_o;

    int              n_vec;
    int              n_fail;
    logic [XLEN-1:0] last_wdata;
    logic [4:0]      last_rd;

    ex_muldiv_sched #(
        .XLEN (XLEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .opcode_i   (opcode_i),
        .funct3_i   (funct3_i),
        .funct7_i   (funct7_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rd_addr_i  (rd_addr_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rd_addr_o  (rd_addr_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: RISC-V M semantics computed with plain wide arithmetic
    function automatic logic [63:0] ref_res(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       p_ss;
        logic [127:0]       p_su;
        logic [127:0]       p_uu;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic               ovf;
        sa   = a;
        sb   = b;
        p_ss = {{64{a[63]}}, a} * {{64{b[63]}}, b};
        p_su = {{64{a[63]}}, a} * {64'd0, b};
        p_uu = {64'd0, a} * {64'd0, b};
        ovf  = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        case (f3)
            3'd0: return p_uu[63:0];
            3'd1: return p_ss[127:64];
            3'd2: return p_su[127:64];
            3'd3: return p_uu[127:64];
            3'd4: begin
                if (b == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
                if (ovf) return a;
                q = sa / sb;
                return q;
            end
            3'd5: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 64'd0;
                q = sa % sb;
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from accept to done: 1 for the non-iterating cases, XLEN+1 otherwise
    function automatic int ref_lat(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
            return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [63:0] rnd_operand();
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0: v = 64'd0;
            1: v = 64'h8000_0000_0000_0000;
            2: v = 64'hFFFF_FFFF_FFFF_FFFF;
            3: v = 64'($urandom_range(1, 1000));
            4: v = -64'($urandom_range(1, 1000));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle with no M op accepted; pipeline must not stall
    task automatic idle_cycle(input bit v, input logic [6:0] opc, input logic [6:0] f7, input string tag);
        @(negedge clk);
        rst        = 1'b0;
        flush_i    = 1'b0;
        valid_i    = v;
        opcode_i   = opc;
        funct7_i   = f7;
        funct3_i   = 3'($urandom);
        rs1_data_i = rnd_operand();
        rs2_data_i = rnd_operand();
        rd_addr_i  = 5'($urandom);
        #1;
        check({tag, "_ctl"},   {stall_o, busy_o, done_o, wreg_o}, 4'b0000);
        check({tag, "_wdata"}, wdata_o, last_wdata);
        check({tag, "_rd"},    rd_addr_o, last_rd);
    endtask

    // Issue an M op and follow it cycle by cycle; valid_i stays high through DONE.
    // abort_at > 0 raises flush_i (or rst) in that cycle and returns afterwards.
    task automatic run_op(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input int abort_at, input bit abort_rst,
                          input string tag);
        logic [63:0] exp;
        int          lat;
        exp = ref_res(f3, a, b);
        lat = ref_lat(f3, a, b);
        @(negedge clk);
        rst        = 1'b0;
        flush_i    = 1'b0;
        valid_i    = 1'b1;
        opcode_i   = 7'b0110011;
        funct7_i   = 7'b0000001;
        funct3_i   = f3;
        rs1_data_i = a;
        rs2_data_i = b;
        rd_addr_i  = rd;
        #1;
        check({tag, "_accept"}, {stall_o, busy_o, done_o, wreg_o}, 4'b1000);
        check({tag, "_hold"},   wdata_o, last_wdata);
        last_rd = rd;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                if (abort_rst) rst = 1'b1;
                else           flush_i = 1'b1;
            end
            #1;
            check({tag, "_busy"}, {stall_o, busy_o, done_o, wreg_o}, 4'b1100);
            if (k == abort_at) return;
        end
        @(negedge clk);
        #1;
        check({tag, "_done"},  {stall_o, busy_o, done_o, wreg_o}, {3'b011, rd != 5'd0});
        check({tag, "_wdata"}, wdata_o, exp);
        check({tag, "_rd"},    rd_addr_o, rd);
        last_wdata = exp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        n_vec      = 0;
        n_fail     = 0;
        last_wdata = '0;
        last_rd    = '0;
        rst        = 1'b1;
        valid_i    = 1'b0;
        flush_i    = 1'b0;
        opcode_i   = '0;
        funct3_i   = '0;
        funct7_i   = '0;
        rs1_data_i = '0;
        rs2_data_i = '0;
        rd_addr_i  = '0;
        repeat (3) @(negedge clk);

        // Reset state, then non-M and invalid instructions do nothing
        idle_cycle(1'b0, 7'b0110011, 7'b0000001, "reset");
        idle_cycle(1'b1, 7'b0110011, 7'b0000000, "add_op");
        idle_cycle(1'b1, 7'b0010011, 7'b0000001, "imm_op");
        idle_cycle(1'b0, 7'b0110011, 7'b0000001, "no_valid");

        // Basic multiply and divide
        run_op(3'd0, 64'd3, -64'd5, 5'd5, 0, 1'b0, "mul_3x-5");
        idle_cycle(1'b0, 7'b0, 7'b0, "gap1");
        run_op(3'd5, 64'd100, 64'd7, 5'd1, 0, 1'b0, "divu");
        run_op(3'd7, 64'd100, 64'd7, 5'd2, 0, 1'b0, "remu");
        run_op(3'd4, -64'd7, 64'd2, 5'd3, 0, 1'b0, "div_neg");
        run_op(3'd6, -64'd7, 64'd2, 5'd4, 0, 1'b0, "rem_neg");

        // High-half multiplies
        run_op(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 0, 1'b0, "mulhu");
        run_op(3'd1, -64'd1, -64'd1, 5'd7, 0, 1'b0, "mulh");
        run_op(3'd2, -64'd1, 64'd2, 5'd8, 0, 1'b0, "mulhsu");

        // Single-cycle special cases
        run_op(3'd4, 64'h1234_5678, 64'd0, 5'd9, 0, 1'b0, "div_by0");
        run_op(3'd6, 64'h1234_5678, 64'd0, 5'd10, 0, 1'b0, "rem_by0");
        run_op(3'd4, 64'h8000_0000_0000_0000, -64'd1, 5'd11, 0, 1'b0, "div_ovf");
        run_op(3'd6, 64'h8000_0000_0000_0000, -64'd1, 5'd0, 0, 1'b0, "rem_ovf_x0");
        idle_cycle(1'b0, 7'b0, 7'b0, "gap2");

        // Flush at T+10 of a DIV, MUL accepted the following cycle
        run_op(3'd4, 64'd1000, 64'd3, 5'd12, 10, 1'b0, "div_flush");
        run_op(3'd0, 64'd11, 64'd13, 5'd13, 0, 1'b0, "mul_after_flush");

        // Reset at T+20 mid-op returns every output to its reset value
        run_op(3'd1, {$urandom, $urandom}, {$urandom, $urandom}, 5'd14, 20, 1'b1, "mulh_rst");
        last_wdata = '0;
        last_rd    = '0;
        idle_cycle(1'b0, 7'b0110011, 7'b0000001, "post_rst");

        // Randomized ops, mixing back-to-back issue with idle gaps
        for (int i = 0; i < 16; i++) begin
            run_op(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(),
                   5'($urandom_range(0, 31)), 0, 1'b0, "rand");
            if ($urandom_range(0, 1) == 1)
                idle_cycle(1'b0, 7'b0110011, 7'b0000001, "rand_gap");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
